// File: rtl/present_enc_ctrl.sv
// present_enc_ctrl: feeds PRESENT-80 core, tracks its 32-round schedule, returns ciphertext.
// Latency: accept edge E0 -> out_valid at E0+33; one pair in flight at a time.
// Backpressure: in_ready low while busy or holding a result; out_ct held until out_ready.
// Optional build macro PRESENT_DONE_CHECK_EN adds a sticky core_done schedule check on err.
module present_enc_ctrl #(
   parameter int DATA_W   = 64,
   parameter int KEY_W    = 80,
   parameter int LAST_RND = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pt,
   input  logic [KEY_W-1:0]  in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_ct,
   output logic              busy,
   output logic              err,
   output logic [DATA_W-1:0] core_idat,
   output logic [KEY_W-1:0]  core_key,
   output logic              core_load,
   input  logic [DATA_W-1:0] core_odat,
   input  logic              core_done
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPT} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [4:0] cnt;
   logic       accept;
   logic       last_rnd;

   // Input is refused while a result is still waiting downstream, so a
   // handshake on the output only re-opens the input on the next cycle.
   assign in_ready = (state == IDLE) & ~out_valid & ~rst;
   assign accept   = in_valid & in_ready;
   assign last_rnd = (cnt == 5'(LAST_RND));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode plus the core load strobe and busy flag.
   always_comb begin
      state_nxt = state;
      core_load = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = LOAD;
         end
         LOAD: begin
            core_load = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (last_rnd) state_nxt = CAPT;
         end
         CAPT: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands stay on the core pins from accept until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_idat <= '0;
         core_key  <= '0;
      end else if (accept) begin
         core_idat <= in_pt;
         core_key  <= in_key;
      end
   end

   // Private copy of the core's round counter; starts at 1 when the core loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case (state)
            LOAD:    cnt <= 5'd1;
            WAIT:    cnt <= last_rnd ? 5'd0 : cnt + 5'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Result capture and output handshake; out_ct keeps its value after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ct    <= '0;
      end else if (state == CAPT) begin
         out_valid <= 1'b1;
         out_ct    <= core_odat;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PRESENT_DONE_CHECK_EN
   // Sticky flag: core_done must be low through WAIT and high in CAPT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if (((state == WAIT) && core_done) || ((state == CAPT) && !core_done))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Directed bench for present_enc_ctrl with a behavioural PRESENT-80 core model.
// Expected ciphertexts are queued at accept and popped when out_valid appears.
module tb_present_enc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pt;
   logic [79:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_ct;
   logic        busy;
   logic        err;
   logic [63:0] core_idat;
   logic [79:0] core_key;
   logic        core_load;
   logic [63:0] core_odat = '0;
   logic        core_done = 1'b0;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   present_enc_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
      .busy(busy), .err(err),
      .core_idat(core_idat), .core_key(core_key), .core_load(core_load),
      .core_odat(core_odat), .core_done(core_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- PRESENT-80 reference ----------------
   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
         4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
         4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
         4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
      logic [63:0] s;
      logic [63:0] t;
      logic [79:0] k;
      s = pt;
      k = key;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
         t = '0;
         for (int b = 0; b < 63; b++) t[(b*16) % 63] = s[b];
         t[63] = s[63];
         s = t;
         k = {k[18:0], k[79:19]};
         k[79:76] = sbox(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   // ---------------- core model (no reset, like the real core) ----------------
   logic [4:0]  rc = '0;
   logic [63:0] m_ct = '0;
   logic        kill_done = 1'b0;

   always @(posedge clk) begin
      if (core_load) begin
         rc        <= 5'd1;
         core_done <= 1'b0;
         m_ct      <= present80(core_idat, core_key);
      end else if (rc == 5'd31) begin
         core_odat <= m_ct;
         core_done <= ~kill_done;
         rc        <= 5'd0;
      end else if (rc != 5'd0) begin
         rc <= rc + 5'd1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Offers a pair from a falling edge; returns the accept edge number.
   task automatic send(input logic [63:0] pt, input logic [79:0] key,
                       input logic [63:0] exp, output int e0);
      int n;
      @(negedge clk);
      in_pt    = pt;
      in_key   = key;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      e0 = cyc + 1;
      if (!in_ready) begin
         chk("accept_timeout", 80'(in_ready), 80'(1'b1));
      end else begin
         exp_q.push_back(exp);
         @(negedge clk);
         in_valid = 1'b0;
         chk("load_pulse", 80'(core_load), 80'(1'b1));
         chk("busy_load",  80'(busy), 80'(1'b1));
         chk("idat_held",  80'(core_idat), 80'(pt));
         chk("key_held",   core_key, key);
         @(negedge clk);
         chk("load_drop",  80'(core_load), 80'(1'b0));
      end
   endtask

   // Waits for out_valid, then checks latency, ciphertext and that input stayed closed.
   task automatic recv(input int e0, input string tag);
      int   n;
      logic saw_rdy;
      n = 0;
      saw_rdy = 1'b0;
      while (!out_valid && n < 100) begin
         if (in_ready) saw_rdy = 1'b1;
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy_low"}, 80'(saw_rdy), 80'(1'b0));
      if (!out_valid) begin
         chk({tag, "_out_timeout"}, 80'(out_valid), 80'(1'b1));
      end else if (exp_q.size() == 0) begin
         chk({tag, "_unexpected_out"}, 80'(out_valid), 80'(1'b0));
      end else begin
         chk({tag, "_latency"}, 80'(cyc - e0), 80'(33));
         chk({tag, "_ct"}, 80'(out_ct), 80'(exp_q.pop_front()));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          e0;
      logic        saw;
      logic [63:0] held;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pt     = '0;
      in_key    = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  80'(in_ready),  80'(1'b0));
      chk("rst_out_valid", 80'(out_valid), 80'(1'b0));
      chk("rst_out_ct",    80'(out_ct),    80'(0));
      chk("rst_busy",      80'(busy),      80'(1'b0));
      chk("rst_err",       80'(err),       80'(1'b0));
      chk("rst_core_load", 80'(core_load), 80'(1'b0));
      chk("rst_core_idat", 80'(core_idat), 80'(0));
      chk("rst_core_key",  core_key,       80'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 80'(in_ready), 80'(1'b1));

      // Zero plaintext, zero key.
      send(64'h0, 80'h0, 64'h5579c1387b228445, e0);
      recv(e0, "t1");

      // Mixed patterns back to back with out_ready high.
      send(64'h0, {80{1'b1}}, 64'he72c46c0f5945049, e0);
      recv(e0, "t2");
      send({64{1'b1}}, 80'h0, 64'ha112ffc72f68417b, e0);
      recv(e0, "t3");

      // Backpressure: result must hold while out_ready is low.
      @(negedge clk);
      out_ready = 1'b0;
      send({64{1'b1}}, {80{1'b1}}, 64'h3333dcd3213210d2, e0);
      recv(e0, "t4");
      held     = out_ct;
      in_valid = 1'b1;
      in_pt    = 64'h0123456789abcdef;
      in_key   = 80'h1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", 80'(out_valid), 80'(1'b1));
         chk("hold_ct",    80'(out_ct),    80'(64'h3333dcd3213210d2));
         chk("hold_rdy",   80'(in_ready),  80'(1'b0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("release_valid",  80'(out_valid), 80'(1'b0));
      chk("release_rdy",    80'(in_ready),  80'(1'b1));
      chk("release_no_acc", 80'(busy),      80'(1'b0));
      chk("release_ct_kept", 80'(out_ct),   80'(held));

      // Reset in the middle of a transaction discards the result.
      send(64'hdeadbeefcafef00d, 80'h55, 64'h0, e0);
      while (cyc < e0 + 15) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy",  80'(busy),      80'(1'b0));
      chk("midrst_load",  80'(core_load), 80'(1'b0));
      chk("midrst_rdy",   80'(in_ready),  80'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      chk("midrst_no_out", 80'(saw), 80'(1'b0));
      send(64'h0, 80'h0, 64'h5579c1387b228445, e0);
      recv(e0, "t5");
      chk("err_clean", 80'(err), 80'(1'b0));

`ifdef PRESENT_DONE_CHECK_EN
      // Core fails to raise done in CAPT: err must latch until reset.
      kill_done = 1'b1;
      send(64'h0, 80'h0, 64'h5579c1387b228445, e0);
      recv(e0, "t6");
      repeat (5) @(negedge clk);
      chk("err_set",    80'(err), 80'(1'b1));
      kill_done = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("err_cleared", 80'(err), 80'(1'b0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
